// File: rtl/dense1_seq.sv
// dense1_seq -- frame sequencer that streams one input vector from a word
// buffer into a dense layer and checks how many outputs the layer returns.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, abort                frame request / synchronous cancel
//   mem_rd_en, mem_addr         buffer read strobe and address
//   mem_rd_data                 buffer read data (one cycle after mem_rd_en)
//   ena, frame_start_in,
//   frame_end_in, dense_input   word stream into the dense layer
//   valid, frame_end_out        output strobes from the dense layer
//   busy, done, err_count       status: frame active, end pulse, count mismatch
//
// Build option: define DENSE1_SEQ_TIMEOUT_EN to add a DRAIN watchdog that ends
// the frame with an error after 4095 quiet cycles.
module dense1_seq #(
    parameter int N_IN   = 980,
    parameter int N_OUT  = 120,
    parameter int ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic signed [15:0]       mem_rd_data,
    output logic                     ena,
    output logic                     frame_start_in,
    output logic                     frame_end_in,
    output logic signed [15:0]       dense_input,
    input  logic                     valid,
    input  logic                     frame_end_out,
    output logic                     busy,
    output logic                     done,
    output logic                     err_count
);

    // One spare code above N_OUT so a saturated counter can never alias N_OUT.
    localparam int                CNT_W     = $clog2(N_OUT + 2);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_EXP   = CNT_W'(N_OUT);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_IN - 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    // Stage 1 tracks the word whose read data arrives this cycle.
    logic               s1_vld_q, s1_vld_d;
    logic               s1_first_q, s1_first_d;
    logic               s1_last_q, s1_last_d;
    logic               ena_q, ena_d;
    logic               fs_q, fs_d;
    logic               fe_q, fe_d;
    logic signed [15:0] din_q, din_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   cnt_now;

`ifdef DENSE1_SEQ_TIMEOUT_EN
    localparam logic [15:0] WD_LIMIT = 16'd4095;
    logic [15:0] wd_q, wd_d;
`endif

    assign cnt_inc = (cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
    // Count including a valid arriving in the same cycle as frame_end_out.
    assign cnt_now = valid ? cnt_inc : cnt_q;

    always_comb begin
        state_d    = state_q;
        rd_en_d    = rd_en_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        done_d     = 1'b0;
        din_d      = din_q;
`ifdef DENSE1_SEQ_TIMEOUT_EN
        wd_d       = 16'd0;
`endif

        // Read pipeline runs independently of the state so the last two
        // words still flow out after the FSM has moved to DRAIN.
        s1_vld_d   = rd_en_q;
        s1_first_d = rd_en_q && (addr_q == '0);
        s1_last_d  = rd_en_q && (addr_q == ADDR_LAST);
        ena_d      = s1_vld_q;
        fs_d       = s1_first_q;
        fe_d       = s1_last_q;
        if (s1_vld_q) din_d = mem_rd_data;

        case (state_q)
            IDLE: begin
                rd_en_d = 1'b0;
                addr_d  = '0;
                if (start) begin
                    state_d = FEED;
                    rd_en_d = 1'b1;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            FEED: begin
                if (valid) cnt_d = cnt_inc;
                if (addr_q == ADDR_LAST) begin
                    state_d = DRAIN;
                    rd_en_d = 1'b0;   // address parks at the last word
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (valid) cnt_d = cnt_inc;
                if (frame_end_out) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (cnt_now != CNT_EXP) err_d = 1'b1;
                end
`ifdef DENSE1_SEQ_TIMEOUT_EN
                else if (valid) begin
                    wd_d = 16'd0;
                end else begin
                    wd_d = wd_q + 16'd1;
                    if (wd_d == WD_LIMIT) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
                addr_d  = '0;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a simultaneous start, and
        // leaves the error flag and counter as they were.
        if (abort) begin
            state_d    = IDLE;
            rd_en_d    = 1'b0;
            addr_d     = '0;
            s1_vld_d   = 1'b0;
            s1_first_d = 1'b0;
            s1_last_d  = 1'b0;
            ena_d      = 1'b0;
            fs_d       = 1'b0;
            fe_d       = 1'b0;
            done_d     = 1'b0;
            cnt_d      = cnt_q;
            err_d      = err_q;
`ifdef DENSE1_SEQ_TIMEOUT_EN
            wd_d       = 16'd0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            ena_q      <= 1'b0;
            fs_q       <= 1'b0;
            fe_q       <= 1'b0;
            din_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            s1_vld_q   <= s1_vld_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
            ena_q      <= ena_d;
            fs_q       <= fs_d;
            fe_q       <= fe_d;
            din_q      <= din_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

`ifdef DENSE1_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_q <= 16'd0;
        else        wd_q <= wd_d;
    end
`endif

    assign mem_rd_en      = rd_en_q;
    assign mem_addr       = addr_q;
    assign ena            = ena_q;
    assign frame_start_in = fs_q;
    assign frame_end_in   = fe_q;
    assign dense_input    = din_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign err_count      = err_q;

endmodule

// File: tb/tb_dense1_seq.sv
// Bench for dense1_seq with N_IN=4, N_OUT=2. A buffer model answers reads;
// expected addresses and words are queued when a frame is started and
// popped by a monitor whenever the DUT issues a read or asserts ena.
module tb_dense1_seq;

    localparam int N_IN   = 4;
    localparam int N_OUT  = 2;
    localparam int ADDR_W = 12;

    typedef struct packed {
        logic signed [15:0] d;
        logic               fs;
        logic               fe;
    } word_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     start = 1'b0;
    logic                     abort = 1'b0;
    logic                     mem_rd_en;
    logic [ADDR_W-1:0]        mem_addr;
    logic signed [15:0]       mem_rd_data;
    logic                     ena;
    logic                     frame_start_in;
    logic                     frame_end_in;
    logic signed [15:0]       dense_input;
    logic                     valid = 1'b0;
    logic                     frame_end_out = 1'b0;
    logic                     busy;
    logic                     done;
    logic                     err_count;

    logic signed [15:0] mem [0:N_IN-1];
    int    addr_exp [$];
    word_t dat_exp [$];
    int    errors = 0;
    int    checks = 0;
    int    done_cnt = 0;

    dense1_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .ena(ena), .frame_start_in(frame_start_in), .frame_end_in(frame_end_in),
        .dense_input(dense_input), .valid(valid), .frame_end_out(frame_end_out),
        .busy(busy), .done(done), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Buffer model: synchronous read, data one cycle after the strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         mem_rd_data <= '0;
        else if (mem_rd_en) mem_rd_data <= mem[mem_addr[1:0]];
    end

    // Monitor on the falling edge; stimulus changes 1 time unit later.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                checks++;
                if (addr_exp.size() == 0) begin
                    errors++;
                    $display("FAIL rd_addr: unexpected read addr=%0d", mem_addr);
                end else begin
                    int ea;
                    ea = addr_exp.pop_front();
                    if (mem_addr !== ADDR_W'(ea)) begin
                        errors++;
                        $display("FAIL rd_addr: got %0d want %0d", mem_addr, ea);
                    end
                end
            end
            if (ena) begin
                checks++;
                if (dat_exp.size() == 0) begin
                    errors++;
                    $display("FAIL ena: unexpected word %0d", dense_input);
                end else begin
                    word_t w;
                    w = dat_exp.pop_front();
                    if ({dense_input, frame_start_in, frame_end_in} !== {w.d, w.fs, w.fe}) begin
                        errors++;
                        $display("FAIL word: got d=%0d fs=%0b fe=%0b want d=%0d fs=%0b fe=%0b",
                                 dense_input, frame_start_in, frame_end_in, w.d, w.fs, w.fe);
                    end
                end
            end else if (frame_start_in || frame_end_in) begin
                checks++;
                errors++;
                $display("FAIL strobe: fs=%0b fe=%0b without ena", frame_start_in, frame_end_in);
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_mem(input int a, input int b, input int c, input int d);
        mem[0] = 16'(a); mem[1] = 16'(b); mem[2] = 16'(c); mem[3] = 16'(d);
    endtask

    task automatic push_frame();
        for (int i = 0; i < N_IN; i++) begin
            word_t w;
            w.d  = mem[i];
            w.fs = (i == 0);
            w.fe = (i == N_IN - 1);
            addr_exp.push_back(i);
            dat_exp.push_back(w);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_drained(input string tag);
        int n = 0;
        while ((addr_exp.size() != 0 || dat_exp.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL %s: stream not drained, left addr=%0d words=%0d want 0",
                     tag, addr_exp.size(), dat_exp.size());
            addr_exp.delete();
            dat_exp.delete();
        end
    endtask

    // Plays the dense layer: nv valid pulses then frame_end_out.
    task automatic finish_frame(input int nv, input bit fe_with_valid,
                                input bit start_in_done, input bit exp_err,
                                input string tag);
        int d0 = done_cnt;
        for (int i = 0; i < nv; i++) begin
            valid = 1'b1;
            if (fe_with_valid && i == nv - 1) frame_end_out = 1'b1;
            tick();
            valid = 1'b0;
            frame_end_out = 1'b0;
        end
        if (!(fe_with_valid && nv > 0)) begin
            frame_end_out = 1'b1;
            tick();
            frame_end_out = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || err_count !== exp_err || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s done: got done=%0b err=%0b busy=%0b want 1 %0b 1",
                     tag, done, err_count, busy, exp_err);
        end
        if (start_in_done) start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt !== d0 + 1 || err_count !== exp_err) begin
            errors++;
            $display("FAIL %s end: got done=%0b busy=%0b pulses=%0d err=%0b want 0 0 %0d %0b",
                     tag, done, busy, done_cnt - d0, err_count, d0 + 1, exp_err);
        end
    endtask

    task automatic run_frame(input int nv, input bit fe_with_valid, input bit exp_err,
                             input string tag);
        push_frame();
        pulse_start();
        wait_drained(tag);
        finish_frame(nv, fe_with_valid, 1'b0, exp_err, tag);
        tick();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_rd_en, mem_addr, ena, frame_start_in, frame_end_in, dense_input,
             busy, done, err_count} !== '0) begin
            errors++;
            $display("FAIL reset: outputs nonzero rd=%0b addr=%0d ena=%0b din=%0d busy=%0b done=%0b err=%0b want all 0",
                     mem_rd_en, mem_addr, ena, dense_input, busy, done, err_count);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        load_mem(10, -20, 30, -40);
        push_frame();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== '0) begin
            errors++;
            $display("FAIL nominal first: busy=%0b rd=%0b addr=%0d want 1 1 0",
                     busy, mem_rd_en, mem_addr);
        end
        wait_drained("nominal");
        finish_frame(2, 1'b0, 1'b0, 1'b0, "nominal");
        tick();
    endtask

    task automatic test_mismatch();
        load_mem(5, -6, 7, 32767);
        run_frame(3, 1'b0, 1'b1, "mismatch");
        repeat (3) tick();
        checks++;
        if (err_count !== 1'b1) begin
            errors++;
            $display("FAIL mismatch sticky: err=%0b want 1", err_count);
        end
        // start+abort together: abort wins, err unchanged, no frame.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || err_count !== 1'b1) begin
            errors++;
            $display("FAIL start_abort: busy=%0b err=%0b want 0 1", busy, err_count);
        end
        // Next accepted start clears the flag.
        load_mem(-1, 2, -3, 4);
        push_frame();
        pulse_start();
        checks++;
        if (err_count !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%0b want 0", err_count);
        end
        wait_drained("after_mismatch");
        // Too few outputs also flags an error.
        finish_frame(1, 1'b0, 1'b0, 1'b1, "too_few");
        tick();
    endtask

    task automatic test_abort();
        int d0;
        load_mem(100, 200, 300, 400);
        d0 = done_cnt;
        push_frame();
        pulse_start();           // now in FEED cycle 1
        tick();                  // now in FEED cycle 2
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (ena !== 1'b0 || mem_rd_en !== 1'b0 || busy !== 1'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL abort: ena=%0b rd=%0b busy=%0b addr=%0d want 0 0 0 0",
                     ena, mem_rd_en, busy, mem_addr);
        end
        // Addresses 0 and 1 were issued; nothing else of that frame is due.
        checks++;
        if (addr_exp.size() != 2) begin
            errors++;
            $display("FAIL abort reads: remaining=%0d want 2", addr_exp.size());
        end
        addr_exp.delete();
        dat_exp.delete();
        repeat (4) tick();
        checks++;
        if (done_cnt !== d0 || err_count !== 1'b0) begin
            errors++;
            $display("FAIL abort done: pulses=%0d err=%0b want 0 0", done_cnt - d0, err_count);
        end
        run_frame(2, 1'b0, 1'b0, "replay");
    endtask

    task automatic test_back_to_back();
        load_mem(-32768, 1, -1, 12345);
        // IDLE ignores stray dense-layer strobes.
        valid = 1'b1;
        frame_end_out = 1'b1;
        tick();
        tick();
        valid = 1'b0;
        frame_end_out = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_strobes: busy=%0b done=%0b want 0 0", busy, done);
        end
        push_frame();
        pulse_start();
        tick();
        start = 1'b1;            // start while busy is ignored
        tick();
        start = 1'b0;
        wait_drained("busy_start");
        // Second valid coincides with frame_end_out; start during DONE ignored.
        finish_frame(2, 1'b1, 1'b1, 1'b0, "b2b");
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: busy=%0b want 0", busy);
        end
        // Valids during FEED count toward the frame total.
        push_frame();
        pulse_start();
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_drained("feed_valid");
        finish_frame(1, 1'b0, 1'b0, 1'b0, "feed_valid");
        tick();
    endtask

    task automatic test_reset_mid_drain();
        int d0;
        load_mem(7, 8, 9, 10);
        d0 = done_cnt;
        push_frame();
        pulse_start();
        wait_drained("rst_drain");
        valid = 1'b1;
        tick();
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_rd_en, mem_addr, ena, frame_start_in, frame_end_in, dense_input,
             busy, done, err_count} !== '0) begin
            errors++;
            $display("FAIL rst_drain: async outputs busy=%0b din=%0d ena=%0b want all 0",
                     busy, dense_input, ena);
        end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_drain done: pulses=%0d busy=%0b want 0 0", done_cnt - d0, busy);
        end
        load_mem(-5, 15, -25, 35);
        run_frame(2, 1'b0, 1'b0, "post_reset");
    endtask

`ifdef DENSE1_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        load_mem(1, 2, 3, 4);
        push_frame();
        pulse_start();
        wait_drained("timeout");
        while (done !== 1'b1 && n < 4200) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1 || err_count !== 1'b1 || n < 4085) begin
            errors++;
            $display("FAIL timeout: done=%0b err=%0b cycles=%0d want 1 1 ~4093",
                     done, err_count, n);
        end
        repeat (2) tick();
    endtask
`endif

    initial begin
        load_mem(0, 0, 0, 0);
        test_reset();
        test_nominal();
        test_mismatch();
        test_abort();
        test_back_to_back();
        test_reset_mid_drain();
`ifdef DENSE1_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dense1_seq.md
DENSE1_SEQ -- requirements
Module: dense1_seq

Interface
REQ-001 SHALL have parameter N_IN, default 980, input vector length in words (2..4096).
REQ-002 SHALL have parameter N_OUT, default 120, expected output count per frame (1..1024).
REQ-003 SHALL have parameter ADDR_W, default 12, width of the buffer read address.
REQ-004 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to run one frame.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current frame.
REQ-008 SHALL have port mem_rd_en / mem_addr  output  1 / ADDR_W  input-buffer read strobe and address.
REQ-009 SHALL have port mem_rd_data  input  16 signed  read data, valid one cycle after mem_rd_en.
REQ-010 SHALL have port ena / frame_start_in / frame_end_in / dense_input  output  1/1/1/16 signed  drive to dense1.
REQ-011 SHALL have port valid / frame_end_out  input  1/1  output strobes from dense1.
REQ-012 SHALL have port busy / done / err_count  output  1/1/1  status: busy, end-of-frame pulse, count-mismatch flag.

Function
REQ-013 SHALL implement the states IDLE, FEED, DRAIN and DONE.
REQ-014 IDLE: start=1 -> FEED, with busy=1 from the next cycle; start while busy, or in DONE, SHALL be ignored.
REQ-015 FEED: mem_rd_en=1 on N_IN consecutive cycles with mem_addr 0..N_IN-1; after the last issue -> DRAIN.
REQ-016 dense_input SHALL be registered from mem_rd_data, so word k is presented 2 cycles after address k was issued.
REQ-017 ena SHALL be high exactly on the N_IN cycles that carry words 0..N_IN-1.
REQ-018 frame_start_in SHALL be high only with word 0, and frame_end_in only with word N_IN-1.
REQ-019 An output counter SHALL increment on each valid=1 in FEED or DRAIN (overlap allowed) and clear on entering FEED.
REQ-020 DRAIN: on frame_end_out=1 -> DONE.
REQ-021 On frame_end_out=1, err_count SHALL be set if the count, including the current valid, is not equal to N_OUT.
REQ-022 err_count SHALL be sticky until the next start is accepted.
REQ-023 DONE: done=1 for exactly one cycle, then -> IDLE with busy=0.
REQ-024 abort=1 in any state SHALL force IDLE on the next edge: ena, mem_rd_en and frame strobes go low that edge, no done, err_count unchanged.
REQ-025 If abort and start are high in the same cycle, abort SHALL win.
REQ-026 valid or frame_end_out in IDLE SHALL be ignored and SHALL NOT change the counter.
REQ-027 mem_addr SHALL NOT wrap; it SHALL stop at N_IN-1 and return to 0 in IDLE.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, all outputs 0 (dense_input=0, mem_addr=0) and counters 0.
REQ-029 Reset during FEED or DRAIN SHALL discard the frame with no done pulse.
REQ-030 After reset release, the first accepted start is the earliest rising edge with rst_n=1 and start=1.

Configuration
REQ-031 With DENSE1_SEQ_TIMEOUT_EN defined:
- a 16-bit watchdog counts DRAIN cycles without valid or frame_end_out;
- at 4095 cycles, err_count=1 and the block goes to DONE with done pulsed;
- valid or frame_end_out resets the watchdog.
REQ-032 Without DENSE1_SEQ_TIMEOUT_EN, the watchdog logic SHALL be absent and DRAIN waits indefinitely.

Verification
REQ-033 Nominal frame, N_IN=4, N_OUT=2, buffer 10,-20,30,-40: start -> mem_addr 0..3, then dense_input 10,-20,30,-40 with ena=1; frame_start_in with 10, frame_end_in with -40; 2 valid then frame_end_out -> done=1 for 1 cycle, err_count=0.
REQ-034 Count mismatch: same frame with 3 valid before frame_end_out -> done=1 and err_count=1; next start clears err_count.
REQ-035 Abort at the 2nd FEED cycle -> next cycle ena=0, mem_rd_en=0, busy=0; no done; a following start replays from address 0.
REQ-036 Start while busy, and start+abort together -> ignored / IDLE respectively; frame timing unchanged.
REQ-037 rst_n pulsed low mid-DRAIN -> all outputs 0 asynchronously, no done; a new frame afterwards completes normally.
REQ-038 With DENSE1_SEQ_TIMEOUT_EN: no valid in DRAIN -> done and err_count=1 after 4095 cycles.
